// File: rtl/run_sequencer.sv
// Multi-cycle instruction sequencer: IDLE/FETCH/EXEC/MEM_WAIT/DONE with
// Start/Done four-phase handshake, PC update and commit qualification.
// Ports: Clk, Reset_n, Start, Jmp_Flag, Beq_Flag, Mem_Access, Mem_Ready,
//   Halt, Target in; PC, Commit, Mem_Req, Done, Cycle_Count out.
// Option: define CYCLE_COUNT_EN to build the executed-cycle counter.
module run_sequencer #(
  parameter int PC_W = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Jmp_Flag,
  input  logic            Beq_Flag,
  input  logic            Mem_Access,
  input  logic            Mem_Ready,
  input  logic            Halt,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] PC,
  output logic            Commit,
  output logic            Mem_Req,
  output logic            Done,
  output logic [15:0]     Cycle_Count
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic            w_commit;
  logic            w_req;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_pc    <= START_PC;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_commit  = 1'b0;
    w_req     = 1'b0;
    w_pc_next = r_pc;
    unique case (r_state)
      S_IDLE: begin
        w_pc_next = START_PC;
        if (Start) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_EXEC;
      S_EXEC: begin
        // Halt wins over memory access and branch flags
        if (Halt) begin
          w_next = S_DONE;
        end else if (Mem_Access) begin
          w_req = 1'b1;
          if (Mem_Ready) begin
            w_commit = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WAIT;
          end
        end else begin
          w_commit = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (Mem_Ready) begin
          w_commit = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_DONE: begin
        if (!Start) begin
          w_next    = S_IDLE;
          w_pc_next = START_PC;
        end
      end
      default: begin
        w_next    = S_IDLE;
        w_pc_next = START_PC;
      end
    endcase
    // PC advances only on the completing cycle of an instruction
    if (w_commit) begin
      if (Jmp_Flag || Beq_Flag) w_pc_next = Target;
      else                      w_pc_next = r_pc + 1'b1;
    end
  end

  assign PC      = r_pc;
  assign Commit  = w_commit;
  assign Mem_Req = w_req;
  assign Done    = (r_state == S_DONE);

`ifdef CYCLE_COUNT_EN
  logic [15:0] r_cyc;
  logic        w_busy;

  assign w_busy = (r_state == S_FETCH) ||
                  (r_state == S_EXEC)  ||
                  (r_state == S_WAIT);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cyc <= '0;
    end else if (r_state == S_IDLE && Start) begin
      r_cyc <= '0;
    end else if (w_busy && r_cyc != 16'hFFFF) begin
      r_cyc <= r_cyc + 16'd1;
    end
  end

  assign Cycle_Count = r_cyc;
`else
  assign Cycle_Count = '0;
`endif

endmodule
